// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
// Scan controller for a 4-digit multiplexed common-anode FND. Digits are
// strobed one per slot, with a dead time at the start of every slot to
// avoid ghosting. It also handles PWM brightness, leading-zero blanking
// and decimal points. A new value is accepted into a shadow buffer through
// a valid/ready handshake. The shadow is committed only at a frame boundary,
// so a frame never mixes two values.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           display enable; 0 blanks the display and parks the scan at slot 0
//   load_valid   load request
//   load_ready   high while the shadow buffer is empty
//   load_data    16-bit hex value, [3:0] = rightmost digit
//   load_dp      decimal point per digit, bit k = digit k
//   load_lz      leading-zero suppression enable
//   load_bright  brightness 0..7 (7 = always on)
//   SEG          segments a..g,dp on [7:0], 1 = lit (registered)
//   DIGIT        active-low digit enables, one-hot-zero (registered)
//   frame_start  one-cycle pulse when digit 0 starts a new frame (registered)
module fnd_scan_ctrl #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  input  logic        load_lz,
  input  logic [2:0]  load_bright,
  output logic [7:0]  SEG,
  output logic [3:0]  DIGIT,
  output logic        frame_start
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  // Hex to segment pattern, a = bit7 .. g = bit1, bit0 (dp) left clear.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hfc;
      4'h1: pat = 8'h60;
      4'h2: pat = 8'hda;
      4'h3: pat = 8'hf2;
      4'h4: pat = 8'h66;
      4'h5: pat = 8'hb6;
      4'h6: pat = 8'hbe;
      4'h7: pat = 8'he0;
      4'h8: pat = 8'hfe;
      4'h9: pat = 8'he6;
      4'ha: pat = 8'hee;
      4'hb: pat = 8'h3e;
      4'hc: pat = 8'h9c;
      4'hd: pat = 8'h7a;
      4'he: pat = 8'h9e;
      4'hf: pat = 8'h8e;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    digit_q, digit_d;
  logic          frame_start_q, frame_start_d;

  logic [15:0]   sh_data_q, act_data_q;
  logic [3:0]    sh_dp_q, act_dp_q;
  logic          sh_lz_q, act_lz_q;
  logic [2:0]    sh_br_q, act_br_q;

  logic          boundary_s, transfer_s, commit_s;
  logic [3:0]    nib_s, digit_sel_s;
  logic          upper_zero_s, lit_s;
  logic [CW-1:0] act_off_s;
  logic [2:0]    ph_s;
  logic [7:0]    seg_pat_s;

  // Handshake, boundary and commit decisions.
  always_comb begin
    boundary_s = en && (cnt_q == CNT_LAST) && (idx_q == 2'd3);
    transfer_s = load_valid && !pend_q;
    // With en low the scan is parked, so a pending shadow is taken right away.
    commit_s   = pend_q && (boundary_s || !en);
    // Transfer and commit cannot coincide: a transfer needs an empty shadow.
    if (transfer_s) begin
      pend_d = 1'b1;
    end else if (commit_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Slot counter and digit index.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!en) begin
      cnt_d = CNT_ZERO;
      idx_d = 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_ZERO;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Digit select, displayed nibble and leading-zero detection.
  always_comb begin
    nib_s        = 4'h0;
    digit_sel_s  = 4'hf;
    upper_zero_s = 1'b0;
    case (idx_q)
      2'd0: begin
        nib_s        = act_data_q[3:0];
        digit_sel_s  = 4'he;
        upper_zero_s = 1'b0;
      end
      2'd1: begin
        nib_s        = act_data_q[7:4];
        digit_sel_s  = 4'hd;
        upper_zero_s = (act_data_q[15:4] == 12'h000);
      end
      2'd2: begin
        nib_s        = act_data_q[11:8];
        digit_sel_s  = 4'hb;
        upper_zero_s = (act_data_q[15:8] == 8'h00);
      end
      2'd3: begin
        nib_s        = act_data_q[15:12];
        digit_sel_s  = 4'h7;
        upper_zero_s = (act_data_q[15:12] == 4'h0);
      end
      default: begin
        nib_s        = 4'h0;
        digit_sel_s  = 4'hf;
        upper_zero_s = 1'b0;
      end
    endcase
  end

  // Dead time, PWM gating and segment pattern for the next output cycle.
  always_comb begin
    act_off_s = cnt_q - CNT_BLANK;
    ph_s      = act_off_s[2:0];
    lit_s     = en && (cnt_q >= CNT_BLANK) && (ph_s <= act_br_q);
    seg_pat_s = seg_encode(nib_s);
    if (act_lz_q && upper_zero_s) begin
      seg_pat_s[7:1] = 7'h00;
    end else begin
      seg_pat_s[7:1] = seg_pat_s[7:1];
    end
    if (lit_s) begin
      seg_d   = {seg_pat_s[7:1], act_dp_q[idx_q]};
      digit_d = digit_sel_s;
    end else begin
      seg_d   = 8'h00;
      digit_d = 4'hf;
    end
    frame_start_d = boundary_s;
  end

  // Scan state, handshake flag and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= CNT_ZERO;
      idx_q         <= 2'd0;
      pend_q        <= 1'b0;
      seg_q         <= 8'h00;
      digit_q       <= 4'hf;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_q        <= pend_d;
      seg_q         <= seg_d;
      digit_q       <= digit_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Shadow buffer capture on a handshake transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data_q <= 16'h0000;
      sh_dp_q   <= 4'h0;
      sh_lz_q   <= 1'b0;
      sh_br_q   <= 3'd7;
    end else if (transfer_s) begin
      sh_data_q <= load_data;
      sh_dp_q   <= load_dp;
      sh_lz_q   <= load_lz;
      sh_br_q   <= load_bright;
    end
  end

  // Active display settings, updated only by a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data_q <= 16'h0000;
      act_dp_q   <= 4'h0;
      act_lz_q   <= 1'b0;
      act_br_q   <= 3'd7;
    end else if (commit_s) begin
      act_data_q <= sh_data_q;
      act_dp_q   <= sh_dp_q;
      act_lz_q   <= sh_lz_q;
      act_br_q   <= sh_br_q;
    end
  end

  assign load_ready  = !pend_q;
  assign SEG         = seg_q;
  assign DIGIT       = digit_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
- Scan controller for the 4-digit multiplexed FND on the board: common-anode digit enables are active-low (DIGIT), segment lines are active-high (SEG).
- Owns digit sequencing, ghost-suppression dead time, PWM brightness, leading-zero blanking and decimal points.
- A 16-bit hex value is loaded through a valid/ready handshake into a shadow buffer.
- The shadow is committed only at frame boundaries, so the display never tears mid-frame.

Parameters:
- SLOT_CYCLES, 100000, clk cycles per digit slot (100 MHz -> 1 kHz slot, 250 Hz frame); legal range BLANK_CYCLES+8 or more.
- BLANK_CYCLES, 1000, dead-time cycles at the start of every slot with all digits off; must be at least 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  display enable; 0 forces blank and holds the scan at slot 0
- load_valid  in  1  load request
- load_ready  out  1  high when the shadow buffer is empty
- load_data  in  16  hex value; [3:0] is the rightmost digit, [15:12] the leftmost
- load_dp  in  4  decimal point per digit, bit k = digit k
- load_lz  in  1  leading-zero suppression enable
- load_bright  in  3  brightness level 0..7; 7 = full on
- SEG  out  8  segments a..g,dp on [7:0]; 1 = lit
- DIGIT  out  4  active-low digit enable, one-hot-zero
- frame_start  out  1  one-cycle pulse when digit 0 begins a new frame

Behaviour:
- Reset (async assert, sync-released use):
  - SEG=8'h00, DIGIT=4'hf, load_ready=1, frame_start=0.
  - Slot counter cnt=0, digit index idx=0, shadow pending=0.
  - Active value=16'h0000, dp=0, lz=0, bright=7.
- Reset mid-frame aborts the scan and discards any pending shadow.
- Scan counters, when en=1:
  - cnt runs 0..SLOT_CYCLES-1. On wrap, idx advances 0->1->2->3->0.
  - Boundary cycle = cnt==SLOT_CYCLES-1 and idx==3.
- Digit map: idx 0/1/2/3 drives DIGIT 4'he/4'hd/4'hb/4'h7 and displays nibble load_data[4k+3:4k] of the active value.
- Segment encoding (a=bit7 .. g=bit1, dp=bit0):
  - 0 fc, 1 60, 2 da, 3 f2, 4 66, 5 b6, 6 be, 7 e0
  - 8 fe, 9 e6, a ee, b 3e, c 9c, d 7a, e 9e, f 8e
  - SEG[0] is set from active dp[idx].
- Output timing: SEG and DIGIT are registered, so they reflect the cnt/idx state of the previous cycle (1-cycle latency).
- Dead time: while cnt < BLANK_CYCLES, DIGIT=4'hf and SEG=8'h00.
- PWM in the active window:
  - ph = (cnt-BLANK_CYCLES) mod 8.
  - Digit is driven only when ph <= bright; otherwise DIGIT=4'hf and SEG=8'h00.
  - bright=7 means always on; bright=0 means 1/8 duty.
- Leading-zero suppression: when lz=1 and k>0 and nibbles k..3 are all zero, the digit's segments a..g are 0.
  - dp is still shown, and DIGIT is still driven.
  - Digit 0 is never suppressed.
- Handshake:
  - Transfer occurs when load_valid && load_ready.
  - On transfer, data/dp/lz/bright are captured into the shadow, pending<=1, and load_ready<=0 on the next cycle.
  - Inputs are ignored while load_ready=0.
- Commit:
  - At the boundary cycle with pending=1, the shadow is copied to the active registers and pending<=0, so load_ready=1 on the next cycle.
  - The new frame (idx 0, cnt 0) uses the new values.
- Simultaneous transfer and boundary (only possible with pending=0): the data goes to the shadow and commits at the *next* boundary, not this one.
- frame_start is registered and high exactly during the cycle in which cnt==0 and idx==0 following a boundary. It stays low after reset until the first wrap.
- en=0:
  - Next cycle: DIGIT=4'hf, SEG=8'h00, cnt=0, idx=0, frame_start=0.
  - A pending shadow commits on the next clk.
  - When en rises again, scanning restarts from slot 0, with no frame_start pulse for that partial start.

Test Plan (SLOT_CYCLES=16, BLANK_CYCLES=2):
- Reset then load 16'h9032 with bright=7, dp=0, lz=0:
  - load_ready drops for one cycle-after-transfer until the boundary.
  - The next frame shows DIGIT e/d/b/7 with SEG da/f2/fc/e6.
  - Each slot has 2 blank cycles then 14 lit cycles; frame_start pulses every 64 cycles.
- Load 16'h0007 with lz=1 and dp=4'b0100:
  - Digit 0 shows e0.
  - Digit 1 shows 00.
  - Digit 2 shows 01 (dp only).
  - Digit 3 shows 00.
- bright=2: in each slot the digit is lit on ph 0,1,2 and blank on ph 3..7. Over 14 active cycles, the lit cycles are ph positions 0-2 and 8-10.
- Transfer on the exact boundary cycle:
  - The value appears one frame later.
  - A second load_valid held during pending is ignored until load_ready=1, then accepted.
- Drop rst_n mid-slot 2 with a pending load:
  - Outputs go to SEG=00 and DIGIT=f immediately (async).
  - After release the display shows 0000 (SEG fc), and load_ready=1.
- en low for 5 cycles mid-frame with a pending load: outputs blank, the commit happens during en=0, and the scan resumes at DIGIT=e with the new value after the blank window.
